fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Produces pc_4/instruction/valid for decode, and applies decode's stall and jump/branch redirect.
- Holds a one-entry skid buffer so a fetch that completes during a stall is never lost.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, fetches over a req/ready handshake (combinational read data),
// and feeds decode with id_pc_4 / id_instruction / id_valid. A one-entry skid
// buffer catches a fetch that completes while decode is stalled.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall             - decode stall; freezes IF/ID
//   jump_taken        - decode redirect request
//   jump_target       - redirect PC
//   imem_req/addr     - fetch request and address (combinational)
//   imem_rdata/ready  - instruction word and completion strobe
//   id_pc_4, id_instruction, id_valid - IF/ID register outputs
//   debug_pc          - current PC register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic [31:0] debug_pc
);

  localparam logic [0:0] FETCH    = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  logic [0:0]  state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] pendingPc, pendingNext;
  logic        skidValid, skidValidNext;
  logic [31:0] skidPc4, skidPc4Next;
  logic [31:0] skidInstr, skidInstrNext;
  logic [31:0] idPc4Next, idInstrNext;
  logic        idValidNext;
  logic        beat;
  logic [31:0] pcPlus4;

  // Request whenever the skid is free; the address is always the PC, which
  // holds the old fetch address while a redirect waits for its beat.
  assign imem_req  = !rst && !skidValid;
  assign imem_addr = pc;
  assign beat      = imem_req && imem_ready;
  assign pcPlus4   = pc + 32'd4;
  assign debug_pc  = pc;

  // State and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pendingPc      <= 32'h0;
      skidValid      <= 1'b0;
      skidPc4        <= 32'h0;
      skidInstr      <= NOP_INSTR;
      id_pc_4        <= 32'h0;
      id_instruction <= NOP_INSTR;
      id_valid       <= 1'b0;
    end else begin
      state          <= stateNext;
      pc             <= pcNext;
      pendingPc      <= pendingNext;
      skidValid      <= skidValidNext;
      skidPc4        <= skidPc4Next;
      skidInstr      <= skidInstrNext;
      id_pc_4        <= idPc4Next;
      id_instruction <= idInstrNext;
      id_valid       <= idValidNext;
    end
  end

  // Next-state logic: everything holds unless a rule below changes it.
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    pendingNext   = pendingPc;
    skidValidNext = skidValid;
    skidPc4Next   = skidPc4;
    skidInstrNext = skidInstr;
    idPc4Next     = id_pc_4;
    idInstrNext   = id_instruction;
    idValidNext   = id_valid;

    case (state)
      FETCH: begin
        if (stall) begin
          // Jumps are ignored while stalled; decode re-presents them.
          if (beat) begin
            skidPc4Next   = pcPlus4;
            skidInstrNext = imem_rdata;
            skidValidNext = 1'b1;
            pcNext        = pcPlus4;
          end
        end else if (jump_taken) begin
          idPc4Next     = 32'h0;
          idInstrNext   = NOP_INSTR;
          idValidNext   = 1'b0;
          skidValidNext = 1'b0;
          if (imem_req && !imem_ready) begin
            // Outstanding request must finish at its address before redirecting.
            pendingNext = jump_target;
            stateNext   = REDIRECT;
          end else begin
            pcNext = jump_target;
          end
        end else if (skidValid) begin
          idPc4Next     = skidPc4;
          idInstrNext   = skidInstr;
          idValidNext   = 1'b1;
          skidValidNext = 1'b0;
        end else if (beat) begin
          idPc4Next   = pcPlus4;
          idInstrNext = imem_rdata;
          idValidNext = 1'b1;
          pcNext      = pcPlus4;
        end else begin
          idPc4Next   = 32'h0;
          idInstrNext = NOP_INSTR;
          idValidNext = 1'b0;
        end
      end

      REDIRECT: begin
        if (!stall) begin
          idPc4Next   = 32'h0;
          idInstrNext = NOP_INSTR;
          idValidNext = 1'b0;
          if (jump_taken) begin
            pendingNext = jump_target;
          end
        end
        // Wrong-path beat is dropped; the newest redirect target wins.
        if (beat) begin
          pcNext    = pendingNext;
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

endmodule
